dmem_responder: RTL and testbench

- Data-memory target that answers the load/store port driven by the MIPS pipeline's MEM stage: byte address, write data, 4-bit byte-lane mask, write enable.
- Holds a word-organised single-port array with configurable wait states.
- Posts stores through a one-entry write buffer.
- Returns load data with a valid pulse, and raises busy so the pipeline holds its MEM request until the request is consumed.

---
 rtl/dmem_responder_pkg.sv | 22 ++
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder_bank.sv | 36 +++
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared constants for the data-memory responder slice.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    localparam int STRB_W = 4;
    localparam logic [STRB_W-1:0] STRB_WORD    = 4'b1111;
    localparam logic [STRB_W-1:0] STRB_HALF_LO = 4'b0011;
    localparam logic [STRB_W-1:0] STRB_HALF_HI = 4'b1100;

    localparam int WAIT_W = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_RD_RESP = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_if
// Description : MEM-stage load/store port between pipeline and data memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        busy;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    modport master (output req, we, addr, wdata, wstrb,
                    input  busy, rdata, rvalid, err);
    modport slave  (input  req, we, addr, wdata, wstrb,
                    output busy, rdata, rvalid, err);
endinterface
`default_nettype wire

// File: rtl/dmem_responder_bank.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bank
// Description : Single-port word array, per-byte write enables, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bank
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_idx,
    input  wire logic [31:0]       i_wdata,
    input  wire logic [STRB_W-1:0] i_wstrb,
    output logic [31:0]            o_q
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_re) r_q <= r_mem[i_idx];
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Wait-stated data memory with a one-entry posted write buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    dmem_if.slave     bus
);

    // Both waiting states last at least one cycle, so WAIT=0 still ends on count 0.
    localparam logic [WAIT_W-1:0] c_last = (WAIT == 0) ? '0 : WAIT_W'(WAIT - 1);

    logic [1:0]        r_state, w_state_nxt;
    logic [WAIT_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_wb_valid;
    logic [ADDR_W-1:0] r_wb_idx;
    logic [31:0]       r_wb_data;
    logic [STRB_W-1:0] r_wb_strb;
    logic              r_zero;

    logic [ADDR_W-1:0] w_idx, w_bank_idx;
    logic              w_oor, w_last, w_drain_done;
    logic              w_load, w_store, w_capture, w_oor_load;
    logic              w_busy, w_rvalid, w_err, w_bank_we, w_bank_re;
    logic [31:0]       w_bank_q;
    logic              w_unused_addr;

    assign w_idx         = bus.addr[ADDR_W+1:2];
    assign w_oor         = |bus.addr[31:ADDR_W+2];
    assign w_unused_addr = &{1'b0, bus.addr[1:0]};
    assign w_last        = (r_cnt == c_last);
    assign w_drain_done  = (r_state == ST_DRAIN) && w_last;
    assign w_load        = bus.req && !bus.we && !w_oor;
    assign w_store       = bus.req && bus.we && !w_oor && (bus.wstrb != '0);
    assign w_oor_load    = bus.req && !bus.we && w_oor;
    assign w_capture     = w_store && (!r_wb_valid || w_drain_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_capture)
                    w_state_nxt = ST_DRAIN;
                else if (r_wb_valid)
                    // A load may overtake a parked store only if it touches another word.
                    w_state_nxt = (w_load && (w_idx != r_wb_idx)) ? ST_RD_WAIT : ST_DRAIN;
                else if (w_load)
                    w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (w_last) w_state_nxt = ST_RD_RESP;
                else        w_cnt_nxt   = r_cnt + 1'b1;
            end
            ST_RD_RESP: w_state_nxt = ST_IDLE;
            ST_DRAIN: begin
                if (w_last) w_state_nxt = ST_IDLE;
                else        w_cnt_nxt   = r_cnt + 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        if (w_store)     w_busy = r_wb_valid && !w_drain_done;
        else if (w_load) w_busy = (r_state != ST_RD_RESP);
        w_rvalid  = (r_state == ST_RD_RESP) || w_oor_load;
        w_err     = bus.req && w_oor;
        w_bank_we = w_drain_done;
        w_bank_re = (r_state == ST_RD_WAIT) && w_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_idx   <= '0;
            r_wb_data  <= '0;
            r_wb_strb  <= '0;
        end else if (w_capture) begin
            r_wb_valid <= 1'b1;
            r_wb_idx   <= w_idx;
            r_wb_data  <= bus.wdata;
            r_wb_strb  <= bus.wstrb;
        end else if (w_drain_done) begin
            r_wb_valid <= 1'b0;
        end
    end

    // rdata shows zero after reset or an out-of-range load until the next array read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_zero <= 1'b1;
        else if (w_bank_re)  r_zero <= 1'b0;
        else if (w_oor_load) r_zero <= 1'b1;
    end

    assign w_bank_idx = (r_state == ST_DRAIN) ? r_wb_idx : w_idx;

    dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
        .clk     (clk),
        .i_we    (w_bank_we),
        .i_re    (w_bank_re),
        .i_idx   (w_bank_idx),
        .i_wdata (r_wb_data),
        .i_wstrb (r_wb_strb),
        .o_q     (w_bank_q)
    );

    assign bus.busy   = w_busy;
    assign bus.rvalid = w_rvalid;
    assign bus.err    = w_err;
    assign bus.rdata  = (w_oor_load || r_zero) ? 32'h0 : w_bank_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder (WAIT=2, ADDR_W=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    dmem_if bus ();

    dmem_responder #(.ADDR_W(10), .WAIT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int waits;
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d; bus.wstrb = s;
        waits = 0;
        @(negedge clk);
        while (bus.busy && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        check("store_timeout", 32'(waits < 40), 32'd1);
        @(posedge clk);
        #1;
        bus.req = 1'b0; bus.we = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] d, output int waits);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = a;
        waits = 0;
        @(negedge clk);
        while (!bus.rvalid && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        check("load_timeout", 32'(waits < 40), 32'd1);
        d = bus.rdata;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          w;
        n_pass = 0; n_total = 0;
        rst = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;

        // Reset state
        @(negedge clk);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_err",    32'(bus.err),    32'd0);
        check("rst_rdata",  bus.rdata,       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_store(32'h0, 32'h01020304, 4'b1111);
        idle(4);

        // Load right behind a full-word store waits for the drain
        do_store(32'h10, 32'h12345678, 4'b1111);
        do_load(32'h10, rd, w);
        check("raw_word_data", rd, 32'h12345678);
        check("raw_word_waits", 32'(w), 32'd5);

        // Byte-lane merges
        do_store(32'h10, 32'h0000AB00, 4'b0010);
        do_load(32'h10, rd, w);
        check("lane1_merge", rd, 32'h1234AB78);
        do_store(32'h10, 32'hEE000000, 4'b1000);
        do_load(32'h10, rd, w);
        check("lane3_merge", rd, 32'hEE34AB78);

        // Load latency with an empty buffer
        do_store(32'h20, 32'hCAFEF00D, 4'b1111);
        idle(4);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h20;
        @(negedge clk); check("lat_busy_t0", 32'(bus.busy), 32'd1);
        @(negedge clk); check("lat_busy_t1", 32'(bus.busy), 32'd1);
        @(negedge clk); check("lat_busy_t2", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("lat_rvalid_t3", 32'(bus.rvalid), 32'd1);
        check("lat_busy_t3",   32'(bus.busy),   32'd0);
        check("lat_rdata_t3",  bus.rdata,       32'hCAFEF00D);
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(negedge clk); check("lat_rvalid_t4", 32'(bus.rvalid), 32'd0);
        idle(1);

        // Back-to-back stores
        do_store(32'h30, 32'hA5A5A5A5, 4'b1111);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h34; bus.wdata = 32'h5A5A5A5A; bus.wstrb = 4'b1111;
        @(negedge clk); check("b2b_busy_t1", 32'(bus.busy), 32'd1);
        @(negedge clk); check("b2b_busy_t2", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        bus.req = 1'b0; bus.we = 1'b0;
        do_load(32'h30, rd, w);
        check("b2b_rd_30", rd, 32'hA5A5A5A5);
        do_load(32'h34, rd, w);
        check("b2b_rd_34", rd, 32'h5A5A5A5A);

        // Out-of-range load and store
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h1000;
        @(negedge clk);
        check("oor_ld_busy",   32'(bus.busy),   32'd0);
        check("oor_ld_err",    32'(bus.err),    32'd1);
        check("oor_ld_rvalid", 32'(bus.rvalid), 32'd1);
        check("oor_ld_rdata",  bus.rdata,       32'd0);
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(negedge clk); check("oor_err_clear", 32'(bus.err), 32'd0);
        @(posedge clk); #1;
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h2000; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'b1111;
        @(negedge clk);
        check("oor_st_busy",   32'(bus.busy),   32'd0);
        check("oor_st_err",    32'(bus.err),    32'd1);
        check("oor_st_rvalid", 32'(bus.rvalid), 32'd0);
        @(posedge clk); #1;
        bus.req = 1'b0; bus.we = 1'b0;
        idle(4);
        do_load(32'h0, rd, w);
        check("oor_word0_intact", rd, 32'h01020304);

        // Reset during drain loses the buffered store
        do_store(32'h40, 32'h11223344, 4'b1111);
        idle(4);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h40; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'b1111;
        @(negedge clk); check("rstd_capture_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        bus.req = 1'b0; bus.we = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rstd_busy",   32'(bus.busy),   32'd0);
        check("rstd_rvalid", 32'(bus.rvalid), 32'd0);
        check("rstd_err",    32'(bus.err),    32'd0);
        check("rstd_rdata",  bus.rdata,       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        do_load(32'h40, rd, w);
        check("rstd_word_kept", rd, 32'h11223344);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
